eth_frame_gen: RTL and testbench

- Ethernet test-traffic generator: produces frames on an AXI4-Stream master that feeds the MAC TX client interface, byte-wide, one clock domain.
- Runs while enabled, with a programmable frame length, inter-frame gap, frame count and payload pattern.
- Keeps running totals of frames and bytes sent.
- Sits beside the stats collector and drives the same TX interface that the collector observes, so generated traffic can be checked against the collected stats.

---
 rtl/eth_frame_gen.sv | 186 ++++++++++++++++++
 tb/tb_eth_frame_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_gen.sv
// eth_frame_gen: byte-wide Ethernet test-traffic generator on an AXI4-Stream
// master. Sends frames of programmable length, gap, count and payload
// pattern while enabled, and keeps 64-bit running totals of frames/bytes.
module eth_frame_gen #(
  parameter int unsigned C_MIN_LEN   = 60,
  parameter int unsigned C_MAX_LEN   = 1514,
  parameter logic [31:0] C_LFSR_SEED = 32'hACE12468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        srst,
  input  logic        enable,
  input  logic [15:0] frame_length,
  input  logic [31:0] frame_gap,
  input  logic [31:0] frame_count,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  fill_byte,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        done,
  output logic [63:0] frames_sent,
  output logic [63:0] bytes_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [15:0] MIN_L     = 16'(C_MIN_LEN);
  localparam logic [15:0] MAX_L     = 16'(C_MAX_LEN);
  // Galois form of x^32+x^22+x^2+x+1 for a right-shifting register.
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] gap_q, gap_d;
  logic [1:0]  pat_q, pat_d;
  logic [7:0]  fill_q, fill_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] gcnt_q, gcnt_d;
  logic [63:0] frames_q, frames_d;
  logic [63:0] bytes_q, bytes_d;

  logic        accept;
  logic        last;
  logic        load_cfg;
  logic [15:0] len_clamped;
  logic [31:0] lfsr_next;

  // Clamp the requested length into the legal frame range.
  always_comb begin
    len_clamped = frame_length;
    if (frame_length < MIN_L)      len_clamped = MIN_L;
    else if (frame_length > MAX_L) len_clamped = MAX_L;
  end

  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
  assign accept    = (state_q == S_SEND) && m_axis_tready;
  assign last      = (idx_q == len_q - 16'd1);

  // Next-state logic: frame sequencing, config latching, counters, LFSR.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    gap_d    = gap_q;
    pat_d    = pat_q;
    fill_d   = fill_q;
    idx_d    = idx_q;
    lfsr_d   = lfsr_q;
    gcnt_d   = gcnt_q;
    frames_d = frames_q;
    bytes_d  = bytes_q;
    load_cfg = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_cfg = 1'b1;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (accept) begin
          idx_d   = idx_q + 16'd1;
          bytes_d = bytes_q + 64'd1;
          if (pat_q == 2'd1) lfsr_d = lfsr_next;
          if (last) begin
            frames_d = frames_q + 64'd1;
            if ((frame_count != 32'd0) && (frames_d >= {32'd0, frame_count})) begin
              state_d = S_DONE;
            end else if (!enable) begin
              state_d = S_IDLE;
            end else if (gap_q == 32'd0) begin
              // Back-to-back: next frame's first byte follows immediately.
              load_cfg = 1'b1;
            end else if (gap_q == 32'd1) begin
              state_d = S_LOAD;
            end else begin
              state_d = S_GAP;
              gcnt_d  = 32'd1;
            end
          end
        end
      end
      S_GAP: begin
        // The LOAD cycle is the final idle cycle, so the wire sees exactly
        // gap_q tvalid-low cycles between frames.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (gcnt_q >= gap_q - 32'd1) begin
          state_d = S_LOAD;
        end else begin
          gcnt_d = gcnt_q + 32'd1;
        end
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_cfg) begin
      len_d  = len_clamped;
      gap_d  = frame_gap;
      pat_d  = pattern_sel;
      fill_d = fill_byte;
      idx_d  = 16'd0;
    end
  end

  // State and datapath registers; rst_n and srst are equivalent resets.
  always_ff @(posedge clk) begin
    if (!rst_n || srst) begin
      state_q  <= S_IDLE;
      len_q    <= 16'd0;
      gap_q    <= 32'd0;
      pat_q    <= 2'd0;
      fill_q   <= 8'd0;
      idx_q    <= 16'd0;
      lfsr_q   <= C_LFSR_SEED;
      gcnt_q   <= 32'd0;
      frames_q <= 64'd0;
      bytes_q  <= 64'd0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      pat_q    <= pat_d;
      fill_q   <= fill_d;
      idx_q    <= idx_d;
      lfsr_q   <= lfsr_d;
      gcnt_q   <= gcnt_d;
      frames_q <= frames_d;
      bytes_q  <= bytes_d;
    end
  end

  // Stream outputs come straight from registers, so they hold during stalls.
  always_comb begin
    m_axis_tvalid = (state_q == S_SEND);
    m_axis_tlast  = m_axis_tvalid && last;
    m_axis_tdata  = 8'd0;
    if (m_axis_tvalid) begin
      case (pat_q)
        2'd1:    m_axis_tdata = lfsr_q[7:0];
        2'd2:    m_axis_tdata = fill_q;
        default: m_axis_tdata = idx_q[7:0];
      endcase
    end
  end

  assign busy        = (state_q == S_LOAD) || (state_q == S_SEND) || (state_q == S_GAP);
  assign done        = (state_q == S_DONE);
  assign frames_sent = frames_q;
  assign bytes_sent  = bytes_q;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed bench for eth_frame_gen: lengths/clamping, gaps, patterns,
// backpressure stability, back-to-back mode, soft reset and done handling.
module tb_eth_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n, srst, enable;
  logic [15:0] frame_length;
  logic [31:0] frame_gap, frame_count;
  logic [1:0]  pattern_sel;
  logic [7:0]  fill_byte;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        busy, done;
  logic [63:0] frames_sent, bytes_sent;

  int errors = 0;
  int checks = 0;
  logic [7:0] rxq[$];

  eth_frame_gen dut (
    .clk(clk), .rst_n(rst_n), .srst(srst), .enable(enable),
    .frame_length(frame_length), .frame_gap(frame_gap),
    .frame_count(frame_count), .pattern_sel(pattern_sel),
    .fill_byte(fill_byte), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .busy(busy), .done(done),
    .frames_sent(frames_sent), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lnext(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Collect one frame into rxq; reports tlast position, stall/stability
  // violations and tvalid holes inside the frame.
  task automatic get_frame(input bit rnd, input int budget,
                           output int lastp, output int stall_err, output int hole);
    bit started = 1'b0;
    bit stalled = 1'b0;
    logic [7:0] pd = 8'd0;
    logic pl = 1'b0;
    rxq.delete();
    lastp = -1; stall_err = 0; hole = 0;
    for (int c = 0; c < budget; c++) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (m_axis_tlast && !m_axis_tvalid) stall_err++;
      if (m_axis_tvalid) begin
        if (stalled && (m_axis_tdata !== pd || m_axis_tlast !== pl)) stall_err++;
        started = 1'b1;
        if (m_axis_tready) begin
          rxq.push_back(m_axis_tdata);
          stalled = 1'b0;
          if (m_axis_tlast) begin
            lastp = rxq.size() - 1;
            step();
            break;
          end
        end else begin
          stalled = 1'b1; pd = m_axis_tdata; pl = m_axis_tlast;
        end
      end else if (started) begin
        hole++;
      end
      step();
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic count_low(input int budget, output int n);
    n = 0;
    while (!m_axis_tvalid && n < budget) begin
      n++;
      step();
    end
  endtask

  initial begin
    int lp, se, ho, nl, bad;
    logic [31:0] lf;

    rst_n = 1'b0; srst = 1'b0; enable = 1'b0; m_axis_tready = 1'b1;
    frame_length = 16'd64; frame_gap = 32'd12; frame_count = 32'd3;
    pattern_sel = 2'd0; fill_byte = 8'h00;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_frames", frames_sent, 64'd0);
    chk("rst_bytes", bytes_sent, 64'd0);

    // 1: three 64-byte incrementing frames with 12-cycle gaps
    enable = 1'b1;
    step();
    chk("t1_load_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t1_load_busy", 64'(busy), 64'd1);
    step();
    chk("t1_lat_tvalid", 64'(m_axis_tvalid), 64'd1);
    for (int f = 0; f < 3; f++) begin
      get_frame(1'b0, 200, lp, se, ho);
      bad = 0;
      foreach (rxq[i]) if (rxq[i] !== 8'(i)) bad++;
      chk("t1_size", 64'(rxq.size()), 64'd64);
      chk("t1_lastpos", 64'(lp), 64'd63);
      chk("t1_data_bad", 64'(bad), 64'd0);
      chk("t1_hole", 64'(ho), 64'd0);
      if (f < 2) begin
        count_low(100, nl);
        chk("t1_gap", 64'(nl), 64'd12);
      end
    end
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_tvalid_done", 64'(m_axis_tvalid), 64'd0);
    chk("t1_frames", frames_sent, 64'd3);
    chk("t1_bytes", bytes_sent, 64'd192);

    // 2: clamping of short and long requests
    enable = 1'b0;
    step();
    chk("t2_done_clr", 64'(done), 64'd0);
    frame_length = 16'd10; frame_count = 32'd1; enable = 1'b1;
    get_frame(1'b0, 200, lp, se, ho);
    chk("t2_min_size", 64'(rxq.size()), 64'd60);
    chk("t2_min_last", 64'(lp), 64'd59);
    chk("t2_min_done", 64'(done), 64'd1);
    enable = 1'b0;
    step();
    frame_length = 16'd2000; enable = 1'b1;
    get_frame(1'b0, 1700, lp, se, ho);
    chk("t2_max_size", 64'(rxq.size()), 64'd1514);
    chk("t2_max_last", 64'(lp), 64'd1513);
    chk("t2_frames", frames_sent, 64'd5);
    chk("t2_bytes", bytes_sent, 64'd1766);

    // 3: LFSR payload under random backpressure
    enable = 1'b0;
    step();
    frame_length = 16'd60; frame_count = 32'd6; pattern_sel = 2'd1; enable = 1'b1;
    get_frame(1'b1, 1000, lp, se, ho);
    lf = 32'hACE12468; bad = 0;
    foreach (rxq[i]) begin
      if (rxq[i] !== lf[7:0]) bad++;
      lf = lnext(lf);
    end
    chk("t3_size", 64'(rxq.size()), 64'd60);
    chk("t3_lfsr_bad", 64'(bad), 64'd0);
    chk("t3_stall_err", 64'(se), 64'd0);
    chk("t3_hole", 64'(ho), 64'd0);

    // 4: back-to-back frames, then enable drop mid-frame
    enable = 1'b0;
    step();
    frame_gap = 32'd0; frame_count = 32'd0; pattern_sel = 2'd0; enable = 1'b1;
    step(); step();
    nl = 0;
    for (int c = 0; c < 1000; c++) begin
      if (!m_axis_tvalid) nl++;
      step();
    end
    chk("t4_b2b_low", 64'(nl), 64'd0);
    for (int c = 0; c < 100 && !(m_axis_tvalid && m_axis_tlast); c++) step();
    step();
    for (int c = 0; c < 30; c++) step();
    chk("t4_byte30", 64'(m_axis_tdata), 64'd30);
    enable = 1'b0;
    get_frame(1'b0, 100, lp, se, ho);
    chk("t4_tail_size", 64'(rxq.size()), 64'd30);
    chk("t4_tail_last", 64'(lp), 64'd29);
    chk("t4_tail_first", 64'(rxq.size() > 0 ? rxq[0] : 8'hFF), 64'd30);
    chk("t4_idle_busy", 64'(busy), 64'd0);
    chk("t4_idle_tvalid", 64'(m_axis_tvalid), 64'd0);

    // 5: soft reset mid-frame restores the LFSR seed
    pattern_sel = 2'd1; frame_gap = 32'd5; enable = 1'b1;
    step(); step();
    for (int c = 0; c < 20; c++) step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t5_frames", frames_sent, 64'd0);
    chk("t5_bytes", bytes_sent, 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    step(); step();
    chk("t5_restart_valid", 64'(m_axis_tvalid), 64'd1);
    chk("t5_first_byte", 64'(m_axis_tdata), 64'h68);

    // 6: constant fill, done hold and re-enable
    enable = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    pattern_sel = 2'd2; fill_byte = 8'hA5; frame_count = 32'd2; frame_gap = 32'd3;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        for (int c = 0; c < 5; c++) step();
        chk("t6_done_hold", 64'(done), 64'd1);
        chk("t6_done_tvalid", 64'(m_axis_tvalid), 64'd0);
        enable = 1'b0;
        step();
        chk("t6_done_clr", 64'(done), 64'd0);
        frame_count = 32'd4; enable = 1'b1;
      end
      get_frame(1'b0, 200, lp, se, ho);
      bad = 0;
      foreach (rxq[i]) if (rxq[i] !== 8'hA5) bad++;
      chk("t6_size", 64'(rxq.size()), 64'd60);
      chk("t6_fill_bad", 64'(bad), 64'd0);
      if (k == 0 || k == 2) begin
        count_low(100, nl);
        chk("t6_gap", 64'(nl), 64'd3);
      end
    end
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_frames", frames_sent, 64'd4);
    chk("t6_bytes", bytes_sent, 64'd240);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
